// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: single-request DDR command scheduler.
//
// Takes one read/write request at a time, consults a per-bank open-row table
// and issues PRE/ACT/RD/WR on the DIMM command bus with tRP/tRCD spacing.
// A free-running interval counter requests periodic refresh. Refresh is
// serviced from IDLE ahead of new requests: PRE-all (only if a bank is open),
// then REF, then a tRFC quiet period.
//
// Ports
//   clk, reset_n           clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake; accepted when both are high
//   req_we                 1 = write, 0 = read
//   req_bg/req_ba          target bank group / bank
//   req_row/req_col        target row / column
//   cs_n, act_n, cke       DIMM control pins
//   addr, ba, bg           DIMM address/command, bank, bank group
//   cmd_done               one-cycle pulse with the RD/WR of the held request
module ddr_cmd_sched #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 4,
  parameter int BANKSPERGROUP = 4,
  parameter int COLS          = 1024,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TRFC          = 16,
  parameter int TREFI         = 512
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [$clog2(BANKGROUPS)-1:0]    req_bg,
  input  logic [$clog2(BANKSPERGROUP)-1:0] req_ba,
  input  logic [ADDRWIDTH-1:0]             req_row,
  input  logic [$clog2(COLS)-1:0]          req_col,
  output logic                             cs_n,
  output logic                             act_n,
  output logic                             cke,
  output logic [ADDRWIDTH-1:0]             addr,
  output logic [$clog2(BANKSPERGROUP)-1:0] ba,
  output logic [$clog2(BANKGROUPS)-1:0]    bg,
  output logic                             cmd_done
);

  localparam int BGW  = $clog2(BANKGROUPS);
  localparam int BAW  = $clog2(BANKSPERGROUP);
  localparam int CW   = $clog2(COLS);
  localparam int NB   = BANKGROUPS * BANKSPERGROUP;
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMAX = (TRFC > TRP) ? ((TRFC > TRCD) ? TRFC : TRCD)
                                     : ((TRP > TRCD) ? TRP : TRCD);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (TREFI > 1) ? $clog2(TREFI) : 1;

  // Wait states are entered the cycle after the command, and the next
  // command issues the cycle after the timer hits zero, so load N-2.
  localparam int RP_LD  = (TRP  > 1) ? TRP  - 2 : 0;
  localparam int RCD_LD = (TRCD > 1) ? TRCD - 2 : 0;
  localparam int RFC_LD = (TRFC > 1) ? TRFC - 2 : 0;

  localparam logic [3:0] OP_PRE = 4'd3;
  localparam logic [3:0] OP_RD  = 4'd4;
  localparam logic [3:0] OP_REF = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_REF, S_WAIT_RFC
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [BGW-1:0]       bg;
    logic [BAW-1:0]       ba;
    logic [ADDRWIDTH-1:0] row;
    logic [CW-1:0]        col;
  } req_t;

  state_e                       state_q, state_d;
  req_t                         req_q, req_d;
  logic                         pre_all_q, pre_all_d;
  logic [TW-1:0]                tmr_q, tmr_d;
  logic [RW-1:0]                refcnt_q, refcnt_d;
  logic                         ref_pend_q, ref_pend_d;
  logic [NB-1:0]                open_q, open_d;
  logic [NB-1:0][ADDRWIDTH-1:0] rowtab_q, rowtab_d;

  logic [IW-1:0] in_idx, q_idx;

  assign in_idx = IW'(req_bg) * IW'(BANKSPERGROUP) + IW'(req_ba);
  assign q_idx  = IW'(req_q.bg) * IW'(BANKSPERGROUP) + IW'(req_q.ba);

  function automatic logic [ADDRWIDTH-1:0] op_addr(input logic [3:0] op);
    op_addr = '0;
    op_addr[ADDRWIDTH-1 -: 4] = op;
  endfunction

  // reset_n gates ready because the flops sit in IDLE during reset.
  assign req_ready = reset_n && (state_q == S_IDLE) && !ref_pend_q;
  assign cke       = reset_n;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      pre_all_q  <= 1'b0;
      tmr_q      <= '0;
      refcnt_q   <= '0;
      ref_pend_q <= 1'b0;
      open_q     <= '0;
      rowtab_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pre_all_q  <= pre_all_d;
      tmr_q      <= tmr_d;
      refcnt_q   <= refcnt_d;
      ref_pend_q <= ref_pend_d;
      open_q     <= open_d;
      rowtab_q   <= rowtab_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    pre_all_d = pre_all_q;
    tmr_d     = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          if (|open_q) begin
            state_d   = S_PRE;
            pre_all_d = 1'b1;
          end else begin
            state_d   = S_REF;
          end
        end else if (req_valid) begin
          req_d     = '{we: req_we, bg: req_bg, ba: req_ba, row: req_row, col: req_col};
          pre_all_d = 1'b0;
          if (!open_q[in_idx])                  state_d = S_ACT;
          else if (rowtab_q[in_idx] == req_row) state_d = S_CAS;
          else                                  state_d = S_PRE;
        end
      end
      S_PRE: begin
        tmr_d   = TW'(RP_LD);
        state_d = (TRP > 1) ? S_WAIT_RP : (pre_all_q ? S_REF : S_ACT);
      end
      S_WAIT_RP: begin
        if (tmr_q == '0) state_d = pre_all_q ? S_REF : S_ACT;
        else             tmr_d   = tmr_q - 1'b1;
      end
      S_ACT: begin
        tmr_d   = TW'(RCD_LD);
        state_d = (TRCD > 1) ? S_WAIT_RCD : S_CAS;
      end
      S_WAIT_RCD: begin
        if (tmr_q == '0) state_d = S_CAS;
        else             tmr_d   = tmr_q - 1'b1;
      end
      S_CAS: state_d = S_IDLE;
      S_REF: begin
        tmr_d   = TW'(RFC_LD);
        state_d = (TRFC > 1) ? S_WAIT_RFC : S_IDLE;
      end
      S_WAIT_RFC: begin
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Open-row table and refresh interval tracking
  always_comb begin
    open_d   = open_q;
    rowtab_d = rowtab_q;
    if (state_q == S_ACT) begin
      open_d[q_idx]   = 1'b1;
      rowtab_d[q_idx] = req_q.row;
    end else if (state_q == S_PRE && !pre_all_q) begin
      open_d[q_idx]   = 1'b0;
    end else if (state_q == S_REF) begin
      open_d          = '0;
    end

    refcnt_d   = (refcnt_q == RW'(TREFI - 1)) ? '0 : refcnt_q + 1'b1;
    ref_pend_d = ref_pend_q;
    if (state_q == S_REF) ref_pend_d = 1'b0;
    // A fresh expiry wins over the clear; an expiry while pending is absorbed.
    if (refcnt_q == RW'(TREFI - 1)) ref_pend_d = 1'b1;
  end

  // Command bus: each command state drives its command for its one cycle.
  always_comb begin
    cs_n     = 1'b1;
    act_n    = 1'b1;
    addr     = '0;
    ba       = '0;
    bg       = '0;
    cmd_done = 1'b0;
    unique case (state_q)
      S_PRE: begin
        cs_n = 1'b0;
        addr = op_addr(OP_PRE);
        if (pre_all_q) begin
          addr[10] = 1'b1;
        end else begin
          ba = req_q.ba;
          bg = req_q.bg;
        end
      end
      S_ACT: begin
        cs_n  = 1'b0;
        act_n = 1'b0;
        addr  = req_q.row;
        ba    = req_q.ba;
        bg    = req_q.bg;
      end
      S_CAS: begin
        cs_n           = 1'b0;
        addr           = op_addr(req_q.we ? OP_WR : OP_RD);
        addr[CW-1:0]   = req_q.col;
        ba             = req_q.ba;
        bg             = req_q.bg;
        cmd_done       = 1'b1;
      end
      S_REF: begin
        cs_n = 1'b0;
        addr = op_addr(OP_REF);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Scoreboard bench for ddr_cmd_sched. A transaction-level model predicts,
// per accepted request or refresh, the timed command list and pushes it into
// a queue; a negedge monitor compares whatever the DUT drives against it.
module tb_ddr_cmd_sched;
  localparam int AW    = 17;
  localparam int TRCD  = 4;
  localparam int TRP   = 4;
  localparam int TRFC  = 16;
  localparam int TREFI = 512;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [1:0]    req_bg = '0, req_ba = '0;
  logic [AW-1:0] req_row = '0;
  logic [9:0]    req_col = '0;
  logic          req_ready, cs_n, act_n, cke, cmd_done;
  logic [AW-1:0] addr;
  logic [1:0]    ba, bg;

  always #5 clk = ~clk;

  ddr_cmd_sched #(
    .ADDRWIDTH(AW), .BANKGROUPS(4), .BANKSPERGROUP(4), .COLS(1024),
    .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TREFI(TREFI)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .cs_n(cs_n), .act_n(act_n), .cke(cke), .addr(addr), .ba(ba), .bg(bg),
    .cmd_done(cmd_done)
  );

  typedef struct packed {
    logic          we;
    logic [1:0]    bg;
    logic [1:0]    ba;
    logic [AW-1:0] row;
    logic [9:0]    col;
  } rq_t;

  // cmd = {act_n, addr, ba, bg, cmd_done}
  typedef struct {
    int          t;
    logic [22:0] cmd;
    string       nm;
  } exp_t;

  int   cyc = 0;
  int   total = 0, bad = 0;
  exp_t exp_q[$];
  rq_t  stim_q[$];
  rq_t  cur;
  bit   have_cur = 0;
  bit   in_rst = 1;
  bit   exp_ready = 0;
  int   gap = 0;

  // reference model state
  bit            m_open[16];
  logic [AW-1:0] m_row[16];
  int            m_free = 0, m_base = 0, m_ref_at = -1, m_last_act = -100;
  bit            m_pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] opa(input int op);
    return AW'(op) << (AW - 4);
  endfunction

  function automatic rq_t rq(input bit we, input int g, input int b, input int row, input int col);
    rq_t r;
    r.we = we; r.bg = 2'(g); r.ba = 2'(b); r.row = AW'(row); r.col = 10'(col);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string info);
    total++;
    bad++;
    $display("FAIL %s @cyc %0d: %s", nm, cyc, info);
  endtask

  task automatic push(input int t, input logic an, input logic [AW-1:0] a,
                      input logic [1:0] b, input logic [1:0] g, input logic d, input string nm);
    exp_t e;
    e.t = t; e.cmd = {an, a, b, g, d}; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Model step for the current cycle, run after inputs for it are driven.
  task automatic model_step();
    int n, t, idx;
    bit expiry, any;
    n = cyc;
    if (in_rst) begin
      exp_ready = 0;
      return;
    end
    expiry    = ((n - m_base) % TREFI) == TREFI - 1;
    exp_ready = (n >= m_free) && !m_pend;
    if (n >= m_free) begin
      if (m_pend) begin
        any = 0;
        foreach (m_open[i]) any |= m_open[i];
        t = n + 1;
        if (any) begin
          push(t, 1'b1, opa(3) | AW'(1 << 10), 2'd0, 2'd0, 1'b0, "pre_all");
          t += TRP;
        end
        push(t, 1'b1, opa(5), 2'd0, 2'd0, 1'b0, "ref");
        m_ref_at = t;
        m_free   = t + TRFC;
        foreach (m_open[i]) m_open[i] = 0;
      end else if (have_cur) begin
        idx = int'(cur.bg) * 4 + int'(cur.ba);
        t   = n + 1;
        if (!(m_open[idx] && m_row[idx] == cur.row)) begin
          if (m_open[idx]) begin
            push(t, 1'b1, opa(3), cur.ba, cur.bg, 1'b0, "pre");
            t += TRP;
          end
          push(t, 1'b0, cur.row, cur.ba, cur.bg, 1'b0, "act");
          m_last_act  = t;
          t          += TRCD;
          m_open[idx] = 1;
          m_row[idx]  = cur.row;
        end
        push(t, 1'b1, opa(cur.we ? 6 : 4) | AW'(cur.col), cur.ba, cur.bg, 1'b1,
             cur.we ? "wr" : "rd");
        m_free   = t + 1;
        have_cur = 0;
      end
    end
    m_pend = (m_pend && n != m_ref_at) || expiry;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!in_rst) begin
      if (!have_cur && stim_q.size() > 0 && $urandom_range(0, gap) == 0) begin
        cur      = stim_q.pop_front();
        have_cur = 1;
      end
      req_valid = have_cur;
      req_we    = have_cur ? cur.we  : 1'($urandom);
      req_bg    = have_cur ? cur.bg  : 2'($urandom);
      req_ba    = have_cur ? cur.ba  : 2'($urandom);
      req_row   = have_cur ? cur.row : AW'($urandom);
      req_col   = have_cur ? cur.col : 10'($urandom);
    end
    model_step();
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    reset_n = 0; in_rst = 1; req_valid = 0; have_cur = 0; exp_ready = 0;
    stim_q.delete();
    exp_q.delete();
    repeat (ncyc - 1) begin @(posedge clk); #1; end
    reset_n = 1; in_rst = 0;
    m_base = cyc; m_free = cyc; m_pend = 0; m_ref_at = -1;
    foreach (m_open[i]) m_open[i] = 0;
    model_step();
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((stim_q.size() > 0 || have_cur || cyc < m_free || exp_q.size() > 0) && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) fail_now("drain_timeout", "sequence did not complete in budget");
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      check("reset_outputs", {cs_n, act_n, addr, ba, bg, cmd_done, cke, req_ready},
            {1'b1, 1'b1, {AW{1'b0}}, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    end else begin
      check("req_ready", req_ready, exp_ready);
      check("cke", cke, 1'b1);
      while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        e = exp_q.pop_front();
        fail_now({"missed_", e.nm}, $sformatf("expected at cyc %0d cmd %h", e.t, e.cmd));
      end
      if (!cs_n || cmd_done) begin
        if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
          e = exp_q.pop_front();
          check(e.nm, {cs_n, act_n, addr, ba, bg, cmd_done}, {1'b0, e.cmd});
        end else begin
          fail_now("unexpected_cmd", $sformatf("got act_n=%b addr=%h ba=%0d bg=%0d done=%b want none",
                   act_n, addr, ba, bg, cmd_done));
        end
      end else begin
        check("nop", {act_n, addr, ba, bg}, {1'b1, {AW{1'b0}}, 2'd0, 2'd0});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    do_reset(3);

    // Idle until first refresh expiry: no bank open, so REF without PRE-all.
    repeat (530) tick();

    // Closed-bank read, then hit write, then row conflict.
    gap = 0;
    stim_q.push_back(rq(0, 1, 2, 'h155, 'h3A));
    stim_q.push_back(rq(1, 1, 2, 'h155, 'h3A));
    stim_q.push_back(rq(0, 1, 2, 'h0AA, 'h3A));
    drain(100);

    // Back-to-back hits with req_valid held high.
    for (int i = 0; i < 6; i++) stim_q.push_back(rq(i[0], 1, 2, 'h0AA, 16 * i + 3));
    drain(100);

    // Reset while waiting on tRCD; the abandoned read must not appear.
    m_last_act = -100;
    stim_q.push_back(rq(0, 0, 0, 'h010, 'h11));
    for (int k = 0; k < 100 && !(m_last_act >= 0 && cyc == m_last_act + 1); k++) tick();
    if (!(m_last_act >= 0 && cyc == m_last_act + 1)) fail_now("act_timeout", "no ACT seen");
    do_reset(3);
    stim_q.push_back(rq(0, 0, 0, 'h010, 'h11));
    drain(100);

    // Randomized traffic over a few refresh intervals.
    gap = 2;
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 2);
      stim_q.push_back(rq(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          (r == 0) ? 'h155 : (r == 1) ? 'h0AA : 'h1F0F, $urandom_range(0, 1023)));
    end
    drain(8000);

    // Refresh expiry with a bank open and req_valid arriving the same cycle.
    gap = 0;
    stim_q.push_back(rq(1, 3, 1, 'h077, 5));
    drain(200);
    p = m_base + ((cyc - m_base) / TREFI + 1) * TREFI;
    if (p <= cyc + 1) p += TREFI;
    while (cyc < p - 1) tick();
    stim_q.push_back(rq(0, 3, 1, 'h077, 9));
    drain(200);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
